// File: rtl/apb_slave_select_ctrl.sv
// rtl/apb_slave_select_ctrl.sv - APB slave decode, one-hot select and response mux with wait-state timeout
module apb_slave_select_ctrl #(
  parameter int                             NUM_SLAVES     = 5,
  parameter int                             SEL_BITS       = 4,
  parameter int                             DATA_WIDTH     = 32,
  parameter logic [NUM_SLAVES*SEL_BITS-1:0] SLOT_ID        = {4'd5, 4'd4, 4'd2, 4'd1, 4'd0},
  parameter logic [NUM_SLAVES-1:0]          SLOT_EN        = {NUM_SLAVES{1'b1}},
  parameter int                             TIMEOUT_CYCLES = 16
) (
  input  logic                             PCLK,
  input  logic                             PRESETn,
  input  logic                             PSEL,
  input  logic                             PENABLE,
  input  logic [SEL_BITS-1:0]              PADDR,
  output logic                             PREADY,
  output logic [DATA_WIDTH-1:0]            PRDATA,
  output logic                             PSLVERR,
  output logic [NUM_SLAVES-1:0]            PSELx,
  input  logic [NUM_SLAVES-1:0]            PREADYx,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATAx,
  input  logic [NUM_SLAVES-1:0]            PSLVERRx,
  output logic                             TIMEOUT_FLAG,
  input  logic                             TIMEOUT_CLR
);

  // A zero timeout still needs a one-bit counter so the ports and regs stay legal
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       sel_q, sel_d;
  logic                   unm_q, unm_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   flag_q;
  logic                   tmo_set;

  logic                   dec_hit;
  logic [IDX_W-1:0]       dec_idx;
  logic [NUM_SLAVES-1:0]  dec_onehot;
  logic [NUM_SLAVES-1:0]  sel_onehot;
  logic                   slv_ready;
  logic [DATA_WIDTH-1:0]  slv_data;
  logic                   slv_err;
  logic                   tmo_hit;

  assign tmo_hit      = TMO_EN && (cnt_q == CNT_MAX);
  assign TIMEOUT_FLAG = flag_q;

  // Slot decode of the current address; scanning downwards lets the lowest index win
  always_comb begin
    dec_hit    = 1'b0;
    dec_idx    = '0;
    dec_onehot = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (SLOT_EN[i] && (PADDR == SLOT_ID[i*SEL_BITS +: SEL_BITS])) begin
        dec_hit = 1'b1;
        dec_idx = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_SLAVES; i++) begin
      dec_onehot[i] = dec_hit && (dec_idx == IDX_W'(i));
    end
  end

  // Response mux from the slave latched at setup
  always_comb begin
    sel_onehot = '0;
    slv_ready  = 1'b0;
    slv_data   = '0;
    slv_err    = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q == IDX_W'(i)) begin
        sel_onehot[i] = 1'b1;
        slv_ready     = PREADYx[i];
        slv_data      = PRDATAx[i*DATA_WIDTH +: DATA_WIDTH];
        slv_err       = PSLVERRx[i];
      end
    end
  end

  // Transfer FSM next state and bridge-facing outputs
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    unm_d   = unm_q;
    cnt_d   = cnt_q;
    tmo_set = 1'b0;
    PSELx   = '0;
    PREADY  = 1'b0;
    PRDATA  = '0;
    PSLVERR = 1'b0;
    case (state_q)
      S_IDLE: begin
        PSELx = dec_onehot & {NUM_SLAVES{PSEL}};
        // An access strobe without a preceding setup is ignored
        if (PSEL && !PENABLE) begin
          state_d = S_ACCESS;
          sel_d   = dec_idx;
          unm_d   = !dec_hit;
          cnt_d   = '0;
        end
      end
      S_ACCESS: begin
        if (!PSEL) begin
          state_d = S_IDLE;
        end else if (unm_q) begin
          PREADY  = 1'b1;
          PSLVERR = 1'b1;
          state_d = S_IDLE;
        end else if (tmo_hit) begin
          PREADY  = 1'b1;
          PSLVERR = 1'b1;
          tmo_set = 1'b1;
          state_d = S_IDLE;
        end else begin
          PSELx = sel_onehot;
          if (slv_ready) begin
            PREADY  = 1'b1;
            PRDATA  = slv_data;
            PSLVERR = slv_err;
            state_d = S_IDLE;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
    endcase
    if (!PRESETn) begin
      PSELx   = '0;
      PREADY  = 1'b0;
      PRDATA  = '0;
      PSLVERR = 1'b0;
    end
  end

  // State, transfer context and sticky timeout flag (set beats clear)
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      unm_q   <= 1'b0;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      unm_q   <= unm_d;
      cnt_q   <= cnt_d;
      if (tmo_set) begin
        flag_q <= 1'b1;
      end else if (TIMEOUT_CLR) begin
        flag_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_apb_slave_select_ctrl.sv
// tb/tb_apb_slave_select_ctrl.sv - bench for apb_slave_select_ctrl across four slot/timeout configurations
module tb_apb_slave_select_ctrl;

  logic         clk = 1'b0;
  logic         presetn;
  logic         psel, penable, tclr;
  logic [3:0]   paddr;
  logic [4:0]   preadyx, pslverrx;
  logic [159:0] prdatax;

  logic [4:0]   pselx_o   [4];
  logic         pready_o  [4];
  logic [31:0]  prdata_o  [4];
  logic         pslverr_o [4];
  logic         flag_o    [4];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // k=0 defaults, k=1 slot 4 disabled, k=2 timeout 4, k=3 timeout disabled
  for (genvar g = 0; g < 4; g++) begin : g_dut
    apb_slave_select_ctrl #(
      .SLOT_EN        (g == 1 ? 5'b01111 : 5'b11111),
      .TIMEOUT_CYCLES (g == 2 ? 4 : (g == 3 ? 0 : 16))
    ) u_dut (
      .PCLK         (clk),
      .PRESETn      (presetn),
      .PSEL         (psel),
      .PENABLE      (penable),
      .PADDR        (paddr),
      .PREADY       (pready_o[g]),
      .PRDATA       (prdata_o[g]),
      .PSLVERR      (pslverr_o[g]),
      .PSELx        (pselx_o[g]),
      .PREADYx      (preadyx),
      .PRDATAx      (prdatax),
      .PSLVERRx     (pslverrx),
      .TIMEOUT_FLAG (flag_o[g]),
      .TIMEOUT_CLR  (tclr)
    );
  end

  // Reference model: transfer-level view per instance
  int         ids  [5] = '{0, 1, 2, 4, 5};
  logic [4:0] m_en [4] = '{5'b11111, 5'b01111, 5'b11111, 5'b11111};
  int         m_to [4] = '{16, 16, 4, 0};
  bit         m_busy  [4];
  int         m_slave [4];
  int         m_waits [4];
  bit         m_flag  [4];

  typedef struct packed {
    logic [4:0]  psel;
    logic        rdy;
    logic [31:0] data;
    logic        err;
    logic        tmo;
  } exp_t;

  function automatic int decode(int k, logic [3:0] a);
    for (int i = 0; i < 5; i++) begin
      if (m_en[k][i] && a == 4'(ids[i])) return i;
    end
    return -1;
  endfunction

  function automatic exp_t model_out(int k);
    exp_t e;
    int   d;
    int   s;
    e = '0;
    if (presetn !== 1'b1) return e;
    if (!m_busy[k]) begin
      d = decode(k, paddr);
      if (psel && d >= 0) e.psel = 5'b00001 << d;
    end else if (psel) begin
      s = m_slave[k];
      if (s < 0) begin
        e.rdy = 1'b1;
        e.err = 1'b1;
      end else if (m_to[k] != 0 && m_waits[k] >= m_to[k]) begin
        e.rdy = 1'b1;
        e.err = 1'b1;
        e.tmo = 1'b1;
      end else begin
        e.psel = 5'b00001 << s;
        if (preadyx[s]) begin
          e.rdy  = 1'b1;
          e.data = prdatax[s*32 +: 32];
          e.err  = pslverrx[s];
        end
      end
    end
    return e;
  endfunction

  exp_t me;
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      me = model_out(k);
      if (!presetn) begin
        m_busy[k] <= 1'b0;
        m_flag[k] <= 1'b0;
      end else begin
        if (me.tmo) m_flag[k] <= 1'b1;
        else if (tclr) m_flag[k] <= 1'b0;
        if (!m_busy[k]) begin
          if (psel && !penable) begin
            m_busy[k]  <= 1'b1;
            m_slave[k] <= decode(k, paddr);
            m_waits[k] <= 0;
          end
        end else if (!psel || me.rdy) begin
          m_busy[k] <= 1'b0;
        end else begin
          m_waits[k] <= m_waits[k] + 1;
        end
      end
    end
  end

  task automatic drive(input bit s, input bit en, input logic [3:0] a,
                       input logic [4:0] rdy, input logic [4:0] err, input bit clr);
    psel     = s;
    penable  = en;
    paddr    = a;
    preadyx  = rdy;
    pslverrx = err;
    tclr     = clr;
    prdatax  = {$urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int c = 0; c < 3; c++) begin
      presetn = 1'b0;
      drive(1'b1, c == 1, 4'(c), 5'h1f, 5'h1f, 1'b0);
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        e = model_out(k);
        n_cmp++;
        if ({pselx_o[k], pready_o[k], prdata_o[k], pslverr_o[k], flag_o[k]} !== {e.psel, e.rdy, e.data, e.err, m_flag[k]}) begin
          n_bad++;
          $display("FAIL reset k=%0d c=%0d got %b/%b/%h/%b/%b want %b/%b/%h/%b/%b", k, c,
                   pselx_o[k], pready_o[k], prdata_o[k], pslverr_o[k], flag_o[k], e.psel, e.rdy, e.data, e.err, m_flag[k]);
        end
        n_cmp++;
        if ({pselx_o[k], pready_o[k], prdata_o[k], pslverr_o[k], flag_o[k]} !== 40'd0) begin
          n_bad++;
          $display("FAIL reset_zero k=%0d got %b/%b/%h/%b/%b want all 0", k,
                   pselx_o[k], pready_o[k], prdata_o[k], pslverr_o[k], flag_o[k]);
        end
      end
      tick();
    end
    presetn = 1'b1;
  endtask

  task automatic test_decode();
    exp_t e;
    logic [4:0] oh;
    logic [31:0] want;
    for (int s = 0; s < 5; s++) begin
      for (int c = 0; c < 3; c++) begin
        drive(c != 2, c == 1, 4'(ids[s]), 5'h1f, 5'h00, 1'b0);
        want = 32'hA5A5_0000 + 32'(s);
        prdatax[s*32 +: 32] = want;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
          e = model_out(k);
          n_cmp++;
          if ({pselx_o[k], pready_o[k], prdata_o[k], pslverr_o[k], flag_o[k]} !== {e.psel, e.rdy, e.data, e.err, m_flag[k]}) begin
            n_bad++;
            $display("FAIL decode k=%0d s=%0d c=%0d got %b/%b/%h/%b/%b want %b/%b/%h/%b/%b", k, s, c,
                     pselx_o[k], pready_o[k], prdata_o[k], pslverr_o[k], flag_o[k], e.psel, e.rdy, e.data, e.err, m_flag[k]);
          end
        end
        oh = 5'b00001 << s;
        if (c == 0) begin
          n_cmp++;
          if (pselx_o[0] !== oh) begin
            n_bad++;
            $display("FAIL decode_setup_psel s=%0d got %b want %b", s, pselx_o[0], oh);
          end
        end
        if (c == 1) begin
          n_cmp++;
          if ({pready_o[0], pslverr_o[0], prdata_o[0]} !== {1'b1, 1'b0, want}) begin
            n_bad++;
            $display("FAIL decode_access s=%0d got rdy=%b err=%b data=%h want 1/0/%h", s, pready_o[0], pslverr_o[0], prdata_o[0], want);
          end
        end
        tick();
      end
    end
  endtask

  task automatic test_unmapped();
    exp_t e;
    logic [3:0] addrs [3] = '{4'd3, 4'd15, 4'd5};
    int kk;
    for (int s = 0; s < 3; s++) begin
      kk = (s == 2) ? 1 : 0;
      for (int c = 0; c < 3; c++) begin
        drive(c != 2, c == 1, addrs[s], 5'($urandom), 5'($urandom), 1'b0);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
          e = model_out(k);
          n_cmp++;
          if ({pselx_o[k], pready_o[k], prdata_o[k], pslverr_o[k], flag_o[k]} !== {e.psel, e.rdy, e.data, e.err, m_flag[k]}) begin
            n_bad++;
            $display("FAIL unmapped k=%0d a=%0d c=%0d got %b/%b/%h/%b/%b want %b/%b/%h/%b/%b", k, addrs[s], c,
                     pselx_o[k], pready_o[k], prdata_o[k], pslverr_o[k], flag_o[k], e.psel, e.rdy, e.data, e.err, m_flag[k]);
          end
        end
        if (c == 0) begin
          n_cmp++;
          if (pselx_o[kk] !== 5'b0) begin
            n_bad++;
            $display("FAIL unmapped_setup a=%0d got psel=%b want 00000", addrs[s], pselx_o[kk]);
          end
        end
        if (c == 1) begin
          n_cmp++;
          if ({pselx_o[kk], pready_o[kk], pslverr_o[kk], prdata_o[kk]} !== {5'b0, 1'b1, 1'b1, 32'h0}) begin
            n_bad++;
            $display("FAIL unmapped_resp a=%0d got psel=%b rdy=%b err=%b data=%h want 00000/1/1/0", addrs[s],
                     pselx_o[kk], pready_o[kk], pslverr_o[kk], prdata_o[kk]);
          end
        end
        tick();
      end
    end
  endtask

  task automatic test_wait_states();
    exp_t e;
    logic [31:0] want;
    for (int c = 0; c < 6; c++) begin
      drive(c != 5, c >= 1 && c <= 4, 4'd2, (c == 4) ? 5'b00100 : 5'b00000, (c == 4) ? 5'b00100 : 5'b00000, 1'b0);
      want = prdatax[2*32 +: 32];
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        e = model_out(k);
        n_cmp++;
        if ({pselx_o[k], pready_o[k], prdata_o[k], pslverr_o[k], flag_o[k]} !== {e.psel, e.rdy, e.data, e.err, m_flag[k]}) begin
          n_bad++;
          $display("FAIL wait k=%0d c=%0d got %b/%b/%h/%b/%b want %b/%b/%h/%b/%b", k, c,
                   pselx_o[k], pready_o[k], prdata_o[k], pslverr_o[k], flag_o[k], e.psel, e.rdy, e.data, e.err, m_flag[k]);
        end
      end
      if (c >= 1 && c <= 3) begin
        n_cmp++;
        if (pready_o[0] !== 1'b0) begin
          n_bad++;
          $display("FAIL wait_stall c=%0d got rdy=%b want 0", c, pready_o[0]);
        end
      end
      if (c == 4) begin
        n_cmp++;
        if ({pready_o[0], pslverr_o[0], prdata_o[0]} !== {1'b1, 1'b1, want}) begin
          n_bad++;
          $display("FAIL wait_done got rdy=%b err=%b data=%h want 1/1/%h", pready_o[0], pslverr_o[0], prdata_o[0], want);
        end
      end
      if (c == 5) begin
        n_cmp++;
        if (flag_o[0] !== 1'b0) begin
          n_bad++;
          $display("FAIL wait_flag got %b want 0", flag_o[0]);
        end
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    int cc;
    for (int c = 0; c < 29; c++) begin
      if (c < 9) begin
        cc = c;
        drive(cc <= 6, cc >= 1 && cc <= 6, 4'd1, 5'h00, 5'h1f, cc == 7);
      end else begin
        cc = c - 9;
        drive(cc <= 18, cc >= 1 && cc <= 18, 4'd1, 5'h00, 5'h00, cc == 5);
      end
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        e = model_out(k);
        n_cmp++;
        if ({pselx_o[k], pready_o[k], prdata_o[k], pslverr_o[k], flag_o[k]} !== {e.psel, e.rdy, e.data, e.err, m_flag[k]}) begin
          n_bad++;
          $display("FAIL timeout k=%0d c=%0d got %b/%b/%h/%b/%b want %b/%b/%h/%b/%b", k, c,
                   pselx_o[k], pready_o[k], prdata_o[k], pslverr_o[k], flag_o[k], e.psel, e.rdy, e.data, e.err, m_flag[k]);
        end
      end
      if (c == 5 || c == 14) begin
        n_cmp++;
        if ({pselx_o[2], pready_o[2], pslverr_o[2], prdata_o[2]} !== {5'b0, 1'b1, 1'b1, 32'h0}) begin
          n_bad++;
          $display("FAIL timeout_resp c=%0d got psel=%b rdy=%b err=%b data=%h want 00000/1/1/0", c,
                   pselx_o[2], pready_o[2], pslverr_o[2], prdata_o[2]);
        end
      end
      if (c == 6 || c == 15) begin
        n_cmp++;
        if (flag_o[2] !== 1'b1) begin
          n_bad++;
          $display("FAIL timeout_flag_set c=%0d got %b want 1", c, flag_o[2]);
        end
      end
      if (c == 8) begin
        n_cmp++;
        if (flag_o[2] !== 1'b0) begin
          n_bad++;
          $display("FAIL timeout_flag_clr got %b want 0", flag_o[2]);
        end
      end
      if (c == 27) begin
        n_cmp++;
        if ({flag_o[0], flag_o[3]} !== 2'b10) begin
          n_bad++;
          $display("FAIL timeout_long got flag0=%b flag3=%b want 1/0", flag_o[0], flag_o[3]);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_abort();
    exp_t e;
    logic [3:0] a;
    for (int c = 0; c < 12; c++) begin
      presetn = (c != 2);
      a = (c < 4) ? 4'd4 : ((c < 7) ? 4'd0 : 4'd2);
      drive(c <= 2 || (c >= 4 && c <= 5) || (c >= 7 && c <= 9),
            c == 1 || c == 2 || c == 5 || c == 8 || c == 9, a,
            (c >= 4 && c <= 6) ? 5'h1f : 5'h00, 5'h00, 1'b0);
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        e = model_out(k);
        n_cmp++;
        if ({pselx_o[k], pready_o[k], prdata_o[k], pslverr_o[k], flag_o[k]} !== {e.psel, e.rdy, e.data, e.err, m_flag[k]}) begin
          n_bad++;
          $display("FAIL reset_abort k=%0d c=%0d got %b/%b/%h/%b/%b want %b/%b/%h/%b/%b", k, c,
                   pselx_o[k], pready_o[k], prdata_o[k], pslverr_o[k], flag_o[k], e.psel, e.rdy, e.data, e.err, m_flag[k]);
        end
      end
      if (c == 2) begin
        n_cmp++;
        if ({pselx_o[0], pready_o[0], prdata_o[0], pslverr_o[0]} !== 39'd0) begin
          n_bad++;
          $display("FAIL midreset got psel=%b rdy=%b data=%h err=%b want all 0", pselx_o[0], pready_o[0], prdata_o[0], pslverr_o[0]);
        end
      end
      if (c == 5) begin
        n_cmp++;
        if ({pready_o[0], pslverr_o[0]} !== 2'b10) begin
          n_bad++;
          $display("FAIL post_reset_xfer got rdy=%b err=%b want 1/0", pready_o[0], pslverr_o[0]);
        end
      end
      if (c == 10 || c == 11) begin
        n_cmp++;
        if (pready_o[0] !== 1'b0) begin
          n_bad++;
          $display("FAIL abort_no_ready c=%0d got %b want 0", c, pready_o[0]);
        end
      end
      tick();
    end
    presetn = 1'b1;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [31:0] want;
    for (int c = 0; c < 5; c++) begin
      drive(c != 4, c == 1 || c == 3, (c < 2) ? 4'd0 : 4'd5, 5'h1f, 5'h00, 1'b0);
      want = (c < 2) ? prdatax[31:0] : prdatax[4*32 +: 32];
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        e = model_out(k);
        n_cmp++;
        if ({pselx_o[k], pready_o[k], prdata_o[k], pslverr_o[k], flag_o[k]} !== {e.psel, e.rdy, e.data, e.err, m_flag[k]}) begin
          n_bad++;
          $display("FAIL b2b k=%0d c=%0d got %b/%b/%h/%b/%b want %b/%b/%h/%b/%b", k, c,
                   pselx_o[k], pready_o[k], prdata_o[k], pslverr_o[k], flag_o[k], e.psel, e.rdy, e.data, e.err, m_flag[k]);
        end
      end
      if (c == 1 || c == 3) begin
        n_cmp++;
        if ({pready_o[0], prdata_o[0]} !== {1'b1, want}) begin
          n_bad++;
          $display("FAIL b2b_done c=%0d got rdy=%b data=%h want 1/%h", c, pready_o[0], prdata_o[0], want);
        end
      end
      if (c == 2) begin
        n_cmp++;
        if (pselx_o[0] !== 5'b10000) begin
          n_bad++;
          $display("FAIL b2b_setup got psel=%b want 10000", pselx_o[0]);
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    exp_t e;
    for (int c = 0; c < 600; c++) begin
      presetn = ($urandom_range(0, 40) != 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
            5'($urandom) & 5'($urandom), 5'($urandom), $urandom_range(0, 7) == 0);
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        e = model_out(k);
        n_cmp++;
        if ({pselx_o[k], pready_o[k], prdata_o[k], pslverr_o[k], flag_o[k]} !== {e.psel, e.rdy, e.data, e.err, m_flag[k]}) begin
          n_bad++;
          $display("FAIL random k=%0d c=%0d got %b/%b/%h/%b/%b want %b/%b/%h/%b/%b", k, c,
                   pselx_o[k], pready_o[k], prdata_o[k], pslverr_o[k], flag_o[k], e.psel, e.rdy, e.data, e.err, m_flag[k]);
        end
      end
      tick();
    end
    presetn = 1'b1;
  endtask

  initial begin
    presetn = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 5'h00, 5'h00, 1'b0);
    test_reset();
    test_decode();
    test_unmapped();
    test_wait_states();
    test_timeout();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_slave_select_ctrl.md
# apb_slave_select_ctrl

Parametrised APB slave-select and response-mux controller for the APB subsystem. It sits between the AHB-to-APB bridge and the peripheral slaves. It decodes a configurable slot map into one-hot slave selects and tracks each transfer through an IDLE/ACCESS state machine. It muxes the selected slave's PREADY/PRDATA/PSLVERR back to the bridge, returns an error for unmapped or disabled slots, and aborts hung slaves with a wait-state timeout plus a sticky status flag.

## Interface
- NUM_SLAVES, 5: number of slave ports.
- SEL_BITS, 4: width of the decode field on PADDR.
- DATA_WIDTH, 32: PRDATA width.
- SLOT_ID, {4'd5,4'd4,4'd2,4'd1,4'd0}: packed NUM_SLAVES*SEL_BITS; slave i responds to decode value SLOT_ID[i*SEL_BITS +: SEL_BITS].
- SLOT_EN, 5'b11111: per-slave enable mask. A disabled slave is treated as unmapped.
- TIMEOUT_CYCLES, 16: wait-state limit. 0 disables the timeout.
- PCLK  in  1  clock.
- PRESETn  in  1  reset, synchronous, active-low.
- PSEL  in  1  subsystem select from the bridge.
- PENABLE  in  1  APB access-phase strobe.
- PADDR  in  SEL_BITS  decode field, already extracted by the bridge.
- PREADY  out  1  muxed ready to the bridge.
- PRDATA  out  DATA_WIDTH  muxed read data.
- PSLVERR  out  1  muxed or generated error.
- PSELx  out  NUM_SLAVES  one-hot slave selects.
- PREADYx  in  NUM_SLAVES  per-slave ready.
- PRDATAx  in  NUM_SLAVES*DATA_WIDTH  per-slave read data; slave i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- PSLVERRx  in  NUM_SLAVES  per-slave error.
- TIMEOUT_FLAG  out  1  sticky timeout status.
- TIMEOUT_CLR  in  1  single-cycle clear of TIMEOUT_FLAG.

## Operation
- Decode: hit[i] = SLOT_EN[i] & (PADDR == SLOT_ID[i]). If several slots hit, the lowest index wins. No hit means unmapped.
- States:
  - IDLE: no transfer in progress.
  - ACCESS: transfer in progress. Registers hold the selected index sel_q, an unmapped flag unm_q and a wait counter cnt (width clog2(TIMEOUT_CYCLES+1)).
- IDLE:
  - PSELx = onehot(decode) & {NUM_SLAVES{PSEL}}. This is combinational so the select is present in the setup phase.
  - On PSEL=1 & PENABLE=0: latch sel_q and unm_q, clear cnt, go to ACCESS.
  - PENABLE=1 seen in IDLE is a protocol violation and is ignored (no transition).
- ACCESS, in priority order:
  - PSEL=0 (abort): go to IDLE. No response, no flag.
  - unm_q=1: PREADY=1, PSLVERR=1, PRDATA=0. No slave is selected. Go to IDLE.
  - cnt==TIMEOUT_CYCLES and TIMEOUT_CYCLES≠0: forced response PREADY=1, PSLVERR=1, PRDATA=0. PSELx is masked to 0 this cycle. TIMEOUT_FLAG is set. Go to IDLE.
  - Otherwise: PSELx = onehot(sel_q) and PREADY/PRDATA/PSLVERR pass through from slave sel_q. If PREADYx[sel_q]=1, go to IDLE; else cnt+1, saturating.
- PRDATA and PSLVERR are 0 whenever PREADY=0.
- TIMEOUT_FLAG:
  - Set by a timeout event.
  - Cleared by TIMEOUT_CLR.
  - Set and clear in the same cycle: set wins.
- Back-to-back transfers: the completion cycle returns to IDLE. A new setup (PSEL=1, PENABLE=0) is accepted on the next cycle with no bubble beyond the APB-mandated setup phase.

## Timing
- Reset (PRESETn=0 sampled at a PCLK edge):
  - State goes to IDLE, cnt=0, sel_q=0, unm_q=0, TIMEOUT_FLAG=0.
  - While PRESETn=0, combinational outputs are forced low: PSELx=0, PREADY=0, PRDATA=0, PSLVERR=0.
- Reset asserted mid-ACCESS abandons the transfer. No response is issued.
- Latency:
  - PSELx is combinational in the setup cycle.
  - Unmapped transfers complete in the first ACCESS cycle (zero wait).
  - Mapped transfers complete in the cycle the slave asserts PREADYx.
  - A timeout response occurs in ACCESS cycle TIMEOUT_CYCLES+1.
- cnt counts only ACCESS cycles with slave PREADY low, and saturates at TIMEOUT_CYCLES.
- With TIMEOUT_CYCLES=0 a transfer waits indefinitely and TIMEOUT_FLAG stays 0.

## Test plan
- Decode sweep with defaults: PADDR=0,1,2,4,5 with PREADYx all 1.
  - Required: PSELx = 00001, 00010, 00100, 01000, 10000 in the setup cycle.
  - Required: PRDATA equals that slave's data (e.g. 32'hA5A5_0000+i).
  - Required: PSLVERR=0 and completion in 1 access cycle.
- Unmapped slots: PADDR=3 and PADDR=15, plus SLOT_EN=5'b01111 with PADDR=5.
  - Required: PSELx=0 throughout; first access cycle has PREADY=1, PSLVERR=1, PRDATA=0.
- Wait states: slave 2 holds PREADYx[2]=0 for 3 access cycles, then asserts it with PSLVERRx[2]=1.
  - Required: PREADY=0 for 3 cycles, then PREADY=1 and PSLVERR=1 passed through.
  - Required: TIMEOUT_FLAG remains 0.
- Timeout: TIMEOUT_CYCLES=4, slave 1 never ready.
  - Required: access cycle 5 has PREADY=1, PSLVERR=1, PRDATA=0, PSELx=0.
  - Required: TIMEOUT_FLAG=1 from the next cycle.
  - TIMEOUT_CLR pulse: flag clears. TIMEOUT_CLR coincident with a second timeout: flag stays 1.
- Reset and abort:
  - PRESETn low in access cycle 2 of a stalled transfer: all outputs 0 from that edge, and a new transfer after release works normally.
  - PSEL dropped mid-ACCESS: return to IDLE with no PREADY pulse.
- Back-to-back: slave 0 read, then slave 4 read on consecutive APB transfers.
  - Required: each transfer completes, and slave 4's setup is accepted on the cycle after slave 0 completes.
